// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo push arbiter.
// Supports DATA_W up to DATA_W_MAX and NUM_REQ up to NUM_REQ_MAX.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned DATA_W_MAX  = 64;
    localparam int unsigned BUS_W_MAX   = NUM_REQ_MAX * DATA_W_MAX;

    // Index width for a counter/pointer spanning n values, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Extract lane idx of width dw from a packed requester bus.
    function automatic logic [DATA_W_MAX-1:0] slice_data(
        input logic [BUS_W_MAX-1:0] bus,
        input int unsigned          idx,
        input int unsigned          dw
    );
        return DATA_W_MAX'(bus >> (idx * dw));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan from farthest to nearest so the nearest candidate after ptr wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (req[PTR_W'(idx)]) begin
                gnt_idx = PTR_W'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one fifo push port among NUM_REQ writers,
// with lockable bursts capped at MAX_BURST beats and a sticky push-error flag.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    input  logic                        fifo_push_err,
    output logic                        fifo_push,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    input  logic                        err_clr,
    output logic                        err_sticky
);

    localparam int unsigned OWNER_W = idx_width(NUM_REQ);
    localparam int unsigned BEAT_W  = idx_width(MAX_BURST);

    state_e              state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                err_q, err_d;
    logic [OWNER_W-1:0]  pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   owner_data;
    logic                beat;
    logic                rel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWNER_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= OWNER_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and transfer logic; full and reset gate the beat with no lag.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        beat         = 1'b0;
        rel          = 1'b0;
        fifo_push    = 1'b0;
        fifo_data_in = '0;
        req_ready    = '0;
        owner_data   = DATA_W'(slice_data(BUS_W_MAX'(req_data), 32'(owner_q), DATA_W));
        err_d        = fifo_push_err ? 1'b1 : (err_clr ? 1'b0 : err_q);

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                beat      = rst_n & req_valid[owner_q] & ~fifo_full;
                fifo_push = beat;
                if (beat) begin
                    fifo_data_in       = owner_data;
                    req_ready[owner_q] = 1'b1;
                end
                rel = (beat & (~req_lock[owner_q] |
                               (beat_cnt_q == BEAT_W'(MAX_BURST - 1)))) |
                      (~req_valid[owner_q] & ~req_lock[owner_q]);
                if (rel) begin
                    state_d    = IDLE;
                    rr_ptr_d   = owner_q;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner      = owner_q;
    assign busy       = (state_q == BURST);
    assign err_sticky = err_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: requester agents, push scoreboard,
// and per-step checks of grant timing, stalls, reset and the error flag.
module tb_fifo_push_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;

    typedef struct {
        logic [7:0] data;
        logic       lock;
    } item_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_push_err;
    logic                      fifo_push;
    logic [DATA_W-1:0]         fifo_data_in;
    logic [1:0]                owner;
    logic                      busy;
    logic                      err_clr;
    logic                      err_sticky;

    item_t req_q [NUM_REQ][$];
    exp_t  exp_q [$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_lock      (req_lock),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_push_err (fifo_push_err),
        .fifo_push     (fifo_push),
        .fifo_data_in  (fifo_data_in),
        .owner         (owner),
        .busy          (busy),
        .err_clr       (err_clr),
        .err_sticky    (err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic lk, input bit expect_it);
        item_t it;
        exp_t  e;
        it.data = d;
        it.lock = lk;
        req_q[r].push_back(it);
        if (expect_it) begin
            e.owner = r;
            e.data  = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_push(input int r, input logic [7:0] d);
        exp_t e;
        e.owner = r;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_sb_empty(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(exp_q.size()), 0);
    endtask

    // Requester agents: pop an item on the edge it was accepted, then present the next.
    initial begin
        logic [NUM_REQ-1:0] rdy;
        rdy       = '0;
        req_valid = '0;
        req_lock  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (rdy[i] === 1'b1 && req_q[i].size() > 0)
                    void'(req_q[i].pop_front());
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_q[i].size() > 0) begin
                    req_valid[i]                   = 1'b1;
                    req_lock[i]                    = req_q[i][0].lock;
                    req_data[i*DATA_W +: DATA_W]   = req_q[i][0].data;
                end else begin
                    req_valid[i]                   = 1'b0;
                    req_lock[i]                    = 1'b0;
                    req_data[i*DATA_W +: DATA_W]   = '0;
                end
            end
        end
    end

    // Push monitor: every push must match the scoreboard head; no push means quiet outputs.
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] one_hot;
        forever begin
            @(negedge clk);
            if (fifo_push === 1'b1) begin
                check("sb_nonempty_on_push", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e       = exp_q.pop_front();
                    one_hot = NUM_REQ'(1) << e.owner;
                    check("push_data", 32'(fifo_data_in), 32'(e.data));
                    check("push_owner", 32'(owner), 32'(e.owner));
                    check("push_ready", 32'(req_ready), 32'(one_hot));
                end
            end else begin
                check("nopush_ready", 32'(req_ready), 0);
                check("nopush_data", 32'(fifo_data_in), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        fifo_full     = 1'b0;
        fifo_push_err = 1'b0;
        err_clr       = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_owner", 32'(owner), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_push", 32'(fifo_push), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_err", 32'(err_sticky), 0);
        tick();
        rst_n = 1'b1;

        // Requesters 0 and 2 single beats: alternate with a one-cycle gap.
        tick();
        add(0, 8'h10, 1'b0, 1'b1);
        add(2, 8'h20, 1'b0, 1'b1);
        add(0, 8'h11, 1'b0, 1'b1);
        add(2, 8'h21, 1'b0, 1'b1);
        sample();
        check("alt_idle_busy", 32'(busy), 0);
        for (int k = 0; k < 8; k++) begin
            int exp_owner [4];
            exp_owner = '{0, 2, 0, 2};
            sample();
            check("alt_push", 32'(fifo_push), 32'((k % 2) == 0));
            if ((k % 2) == 0)
                check("alt_owner", 32'(owner), 32'(exp_owner[k/2]));
        end

        // Requester 1 three-beat locked burst.
        tick();
        add(1, 8'hA1, 1'b1, 1'b1);
        add(1, 8'hA2, 1'b1, 1'b1);
        add(1, 8'hA3, 1'b0, 1'b1);
        sample();
        check("b1_busy_lat", 32'(busy), 0);
        sample();
        check("b1_busy", 32'(busy), 1);
        check("b1_owner", 32'(owner), 1);
        check("b1_push0", 32'(fifo_push), 1);
        sample();
        check("b1_push1", 32'(fifo_push), 1);
        sample();
        check("b1_push2", 32'(fifo_push), 1);
        sample();
        check("b1_release", 32'(busy), 0);

        // Requester 3 locked continuously: MAX_BURST cap, then requester 0, then 3 again.
        tick();
        for (int j = 0; j < 8; j++) begin
            if (j == 4) expect_push(0, 8'h40);
            add(3, 8'(8'h30 + j), 1'b1, 1'b1);
        end
        add(0, 8'h40, 1'b0, 1'b0);
        sample();
        check("cap_idle", 32'(busy), 0);
        repeat (4) begin
            sample();
            check("cap_push_a", 32'(fifo_push), 1);
            check("cap_owner_a", 32'(owner), 3);
        end
        sample();
        check("cap_gap1", 32'(busy), 0);
        sample();
        check("cap_r0_push", 32'(fifo_push), 1);
        check("cap_r0_owner", 32'(owner), 0);
        sample();
        check("cap_gap2", 32'(fifo_push), 0);
        repeat (4) begin
            sample();
            check("cap_push_b", 32'(fifo_push), 1);
            check("cap_owner_b", 32'(owner), 3);
        end
        sample();
        check("cap_release", 32'(busy), 0);

        // Five-cycle full stall in the middle of a requester 1 burst.
        tick();
        add(1, 8'hB0, 1'b1, 1'b1);
        add(1, 8'hB1, 1'b1, 1'b1);
        add(1, 8'hB2, 1'b1, 1'b1);
        add(1, 8'hB3, 1'b0, 1'b1);
        sample();
        check("stall_idle", 32'(busy), 0);
        sample();
        check("stall_first", 32'(fifo_push), 1);
        check("stall_first_owner", 32'(owner), 1);
        tick();
        fifo_full = 1'b1;
        repeat (5) begin
            sample();
            check("stall_push", 32'(fifo_push), 0);
            check("stall_ready", 32'(req_ready), 0);
            check("stall_owner", 32'(owner), 1);
            check("stall_busy", 32'(busy), 1);
            tick();
        end
        fifo_full = 1'b0;
        repeat (3) begin
            sample();
            check("stall_resume", 32'(fifo_push), 1);
        end
        sample();
        check("stall_release", 32'(busy), 0);
        check("stall_no_err", 32'(err_sticky), 0);

        // Reset during beat 2 of a requester 2 locked burst.
        tick();
        add(2, 8'hC0, 1'b1, 1'b1);
        add(2, 8'hC1, 1'b1, 1'b0);
        add(2, 8'hC2, 1'b1, 1'b0);
        add(2, 8'hC3, 1'b0, 1'b0);
        sample();
        check("rb_idle", 32'(busy), 0);
        sample();
        check("rb_beat1", 32'(fifo_push), 1);
        check("rb_owner", 32'(owner), 2);
        tick();
        rst_n = 1'b0;
        add(0, 8'hD0, 1'b0, 1'b1);
        expect_push(2, 8'hC1);
        expect_push(2, 8'hC2);
        expect_push(2, 8'hC3);
        sample();
        check("rb_rst_push", 32'(fifo_push), 0);
        check("rb_rst_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        sample();
        check("rb_after_busy", 32'(busy), 0);
        check("rb_after_push", 32'(fifo_push), 0);
        check("rb_after_owner", 32'(owner), 0);
        sample();
        check("rb_r0_wins_busy", 32'(busy), 1);
        check("rb_r0_wins_owner", 32'(owner), 0);
        check("rb_r0_wins_push", 32'(fifo_push), 1);
        wait_sb_empty(30);

        // Sticky error flag: set, hold, set-wins-over-clear, clear.
        tick();
        fifo_push_err = 1'b1;
        tick();
        fifo_push_err = 1'b0;
        sample();
        check("err_set", 32'(err_sticky), 1);
        tick();
        tick();
        sample();
        check("err_hold", 32'(err_sticky), 1);
        tick();
        fifo_push_err = 1'b1;
        err_clr       = 1'b1;
        tick();
        fifo_push_err = 1'b0;
        err_clr       = 1'b0;
        sample();
        check("err_set_wins", 32'(err_sticky), 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sample();
        check("err_cleared", 32'(err_sticky), 0);

        repeat (3) sample();
        check("sb_final_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the single push port of the `fifo` block among NUM_REQ independent writers.
- Round-robin arbitration with optional locked bursts, capped at MAX_BURST beats.
- Honors `full` back-pressure so `push_err_on_full` never fires in correct operation.
- Sits between the writer agents and the fifo's `push`/`data_in` pins.
- Monitors the fifo's `push_err_on_full` and keeps a sticky error flag.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: fifo data width.
- MAX_BURST, 4: maximum beats per grant (1..16).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_lock  input  NUM_REQ  owner requests to keep the grant after the current beat.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  beat accepted this cycle; one-hot or zero.
- fifo_full  input  1  fifo `full`.
- fifo_push_err  input  1  fifo `push_err_on_full`.
- fifo_push  output  1  drives fifo `push`.
- fifo_data_in  output  DATA_W  drives fifo `data_in`.
- owner  output  $clog2(NUM_REQ)  current grant holder; valid while busy=1.
- busy  output  1  a grant is active (state BURST).
- err_clr  input  1  clears err_sticky.
- err_sticky  output  1  fifo reported a push on full since the last clear.

Behaviour:
- Reset is synchronous on rst_n=0 at posedge clk. Resulting state:
  - state=IDLE, owner=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - beat_cnt=0, err_sticky=0.
  - Combinational outputs settle to req_ready=0, fifo_push=0, busy=0.
  - fifo_data_in=0 whenever fifo_push=0.
- State IDLE:
  - If any req_valid is set, pick the first valid requester searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Next cycle: owner=winner, state=BURST, beat_cnt=0.
  - No transfer happens in IDLE. Arbitration latency is 1 cycle.
- State BURST, transfer rule:
  - beat = req_valid[owner] & ~fifo_full.
  - fifo_push = beat; req_ready[owner] = beat; fifo_data_in = req_data[owner].
  - All other req_ready bits are 0.
- State BURST, release to IDLE at the next edge when any of the following holds:
  - (a) beat and req_lock[owner]=0;
  - (b) beat and beat_cnt==MAX_BURST-1;
  - (c) req_valid[owner]=0 and req_lock[owner]=0 (abandon, no transfer).
- On release, rr_ptr<=owner. Otherwise, on a beat, beat_cnt increments.
- While fifo_full=1 the owner stalls and keeps the grant. The lock or valid state is still evaluated under condition (c).
- Owner with valid=0 and lock=1: the grant is held indefinitely, with no transfer.
- A single-beat grant (lock=0) still costs 2 cycles. Back-to-back single beats from one requester therefore push every other cycle.
- MAX_BURST=1: every grant releases after its first beat, regardless of lock.
- fifo_full rising in the same cycle as a beat candidate: the beat is suppressed. This path is purely combinational, with no registered lag.
- err_sticky:
  - Set on fifo_push_err=1.
  - Cleared on err_clr=1.
  - If both occur in the same cycle, set wins.
- Reset mid-burst: the partial burst is abandoned, with no push in the reset cycle. The fifo's own reset is driven separately.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - localparams for the owner and beat_cnt widths;
  - a function that slices req_data by index.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: gnt_idx, any.
  - Instantiated once in the IDLE path.

Test Plan:
- Requester 1 sends 3 beats with lock=1,1,0 and data A1,A2,A3; fifo never full.
  - busy rises 1 cycle after valid.
  - fifo_push is high for 3 consecutive cycles with data A1,A2,A3.
  - Returns to IDLE, rr_ptr=1.
- Requesters 0 and 2 both valid with lock=0, held for 4 grants.
  - Grant order is 0,2,0,2.
  - Each grant is exactly 1 push followed by a 1-cycle IDLE gap.
- Requester 3 holds lock=1 with valid continuously, MAX_BURST=4.
  - Exactly 4 pushes, then release.
  - Next grant goes to another valid requester if one is present; otherwise requester 3 again.
- fifo_full asserted for 5 cycles mid-burst.
  - fifo_push=0 and req_ready=0 during the stall.
  - owner unchanged.
  - Burst resumes with the next data item; no fifo_push_err.
- Assert rst_n=0 for one cycle during beat 2 of a locked burst.
  - Next cycle busy=0, fifo_push=0, owner=0.
  - Requester 0 wins if valid.
- Force fifo_push_err=1 for one cycle.
  - err_sticky=1 and stays set.
  - err_clr together with fifo_push_err keeps it 1; err_clr alone clears it.
